alu_muldiv_sequencer: RTL and testbench

//  Multi-cycle MULTU/DIVU controller. Drives the shared 32-bit ALU's ADD/SUB
//  ops on each iteration and produces HI/LO results for the MIPS datapath.

---
 rtl/alu_muldiv_sequencer_if.sv | 29 ++
 rtl/alu_muldiv_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_sequencer_if.sv
// Request/response and shared-ALU signals between the MIPS datapath and the
// MULTU/DIVU sequencer.
interface alu_muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [3:0]            alu_operation;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, alu_result,
    input  alu_operation, alu_a, alu_b, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, alu_result,
    output alu_operation, alu_a, alu_b, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller: shift-add multiply and restoring divide,
// one iteration per clock, using the shared ALU for the per-step ADD/SUB.
module alu_muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_muldiv_sequencer_if.slave   bus
);
  localparam int W = DATA_WIDTH;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ITER  = 3'd1;
  localparam logic [2:0] DZERO = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [2:0]           state;
  logic                 op_q;
  logic                 dz_q;
  logic [W-1:0]         acc_hi;
  logic [W-1:0]         acc_lo;
  logic [W-1:0]         mcand;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         hi_q;
  logic [W-1:0]         lo_q;
  logic                 done_q;
  logic                 dbz_q;

  logic                 div_zero_req;
  logic [W:0]           rem;
  logic                 div_ok;
  logic [W-1:0]         mul_sum;
  logic                 mul_c;
  logic [W-1:0]         acc_hi_nx;
  logic [W-1:0]         acc_lo_nx;

  assign div_zero_req    = bus.op && (bus.operand_b == '0);
  assign bus.busy        = (state == ITER) || (state == DZERO);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  always_comb begin
    bus.alu_operation = ALU_AND;
    bus.alu_a         = '0;
    bus.alu_b         = '0;
    rem               = {acc_hi, acc_lo[W-1]};
    div_ok            = rem[W] | (rem[W-1:0] >= mcand);
    mul_sum           = acc_hi;
    mul_c             = 1'b0;
    acc_hi_nx         = acc_hi;
    acc_lo_nx         = acc_lo;
    if (state == ITER) begin
      bus.alu_b = mcand;
      if (op_q) begin
        bus.alu_operation = ALU_SUB;
        bus.alu_a         = rem[W-1:0];
        acc_hi_nx         = div_ok ? bus.alu_result : rem[W-1:0];
        acc_lo_nx         = {acc_lo[W-2:0], div_ok};
      end else begin
        bus.alu_operation = ALU_ADD;
        bus.alu_a         = acc_hi;
        if (acc_lo[0]) begin
          mul_sum = bus.alu_result;
          // carry out of the 32-bit ALU add is recovered by wrap detection
          mul_c   = bus.alu_result < acc_hi;
        end
        {acc_hi_nx, acc_lo_nx} = {mul_c, mul_sum, acc_lo[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= 1'b0;
      dz_q   <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            dz_q   <= div_zero_req;
            dbz_q  <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= bus.op ? bus.operand_a : bus.operand_b;
            mcand  <= bus.op ? bus.operand_b : bus.operand_a;
            state  <= div_zero_req ? DZERO : ITER;
          end
        end
        ITER: begin
          acc_hi <= acc_hi_nx;
          acc_lo <= acc_lo_nx;
          cnt    <= cnt + CNT_WIDTH'(1);
          if (cnt == LAST) state <= DONE;
        end
        DZERO: state <= DONE;
        DONE: begin
          // on divide-by-zero acc_lo still holds the latched dividend
          done_q <= 1'b1;
          dbz_q  <= dz_q;
          hi_q   <= dz_q ? acc_lo : acc_hi;
          lo_q   <= dz_q ? '1 : acc_lo;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Randomized and directed bench for alu_muldiv_sequencer against a
// transaction-level model built from plain 64-bit multiply / divide.
module tb_alu_muldiv_sequencer;
  logic clk;
  logic reset;

  alu_muldiv_sequencer_if #(.DATA_WIDTH(32)) bus ();

  alu_muldiv_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // shared ALU: ADD, SUB, otherwise AND
  assign bus.alu_result = (bus.alu_operation == 4'b0011) ? bus.alu_a + bus.alu_b :
                          (bus.alu_operation == 4'b0100) ? bus.alu_a - bus.alu_b :
                                                           bus.alu_a & bus.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } lit_t;
  lit_t litq[$];

  int checks = 0;
  int errors = 0;

  // model: t = clock edges since accept; L = edges until done is visible
  logic        m_active;
  int          m_t;
  int          m_L;
  logic        m_op;
  logic [31:0] m_mcand;
  logic [31:0] r_hi, r_lo;
  logic        r_dz;
  logic [31:0] m_hi, m_lo;
  logic        m_dz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_L      <= 0;
      m_op     <= 1'b0;
      m_mcand  <= '0;
      m_hi     <= '0;
      m_lo     <= '0;
      m_dz     <= 1'b0;
    end else if ((!m_active || m_t >= m_L) && bus.start) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_dz     <= 1'b0;
      m_op     <= bus.op;
      m_mcand  <= bus.op ? bus.operand_b : bus.operand_a;
      if (bus.op && bus.operand_b == 32'd0) begin
        m_L <= 2; r_hi <= bus.operand_a; r_lo <= 32'hFFFF_FFFF; r_dz <= 1'b1;
      end else if (bus.op) begin
        m_L <= 33; r_hi <= bus.operand_a % bus.operand_b; r_lo <= bus.operand_a / bus.operand_b;
        r_dz <= 1'b0;
      end else begin
        m_L <= 33; {r_hi, r_lo} <= 64'(bus.operand_a) * 64'(bus.operand_b); r_dz <= 1'b0;
      end
    end else if (m_active && m_t <= m_L) begin
      m_t <= m_t + 1;
      if (m_t + 1 == m_L) begin
        m_hi <= r_hi;
        m_lo <= r_lo;
        m_dz <= r_dz;
      end
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    logic iter;
    lit_t l;
    if (reset) begin
      iter = m_active && (m_L == 33) && (m_t < 32);
      chk("busy", 64'(bus.busy), 64'(m_active && (m_t < m_L - 1)));
      chk("done", 64'(bus.done), 64'(m_active && (m_t == m_L)));
      chk("hi", 64'(bus.hi), 64'(m_hi));
      chk("lo", 64'(bus.lo), 64'(m_lo));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(m_dz));
      chk("alu_operation", 64'(bus.alu_operation),
          iter ? (m_op ? 64'h4 : 64'h3) : 64'h0);
      chk("alu_b", 64'(bus.alu_b), iter ? 64'(m_mcand) : 64'h0);
      if (!iter) chk("alu_a_idle", 64'(bus.alu_a), 64'h0);
    end
    while (litq.size() > 0) begin
      l = litq.pop_front();
      chk(l.name, l.act, l.exp);
    end
  end

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    litq.push_back('{name, act, exp});
  endtask

  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input bit check_lit, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int poke);
    int k;
    bit got;
    int lat;
    lat = (o && b == 32'd0) ? 2 : 33;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    k = 0;
    got = 1'b0;
    while (k < 60 && !got) begin
      @(posedge clk);
      k++;
      #1;
      if (bus.done) got = 1'b1;
      else if (k == poke) begin
        bus.start = 1'b1; bus.op = ~o; bus.operand_a = $urandom; bus.operand_b = $urandom;
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    lit("done_seen", 64'(got), 64'h1);
    if (check_lit) begin
      lit("latency", 64'(k), 64'(lat));
      lit("lit_hi", 64'(bus.hi), 64'(eh));
      lit("lit_lo", 64'(bus.lo), 64'(el));
      lit("lit_dz", 64'(bus.div_by_zero), 64'(edz));
      @(posedge clk);
      #1 lit("done_width", 64'(bus.done), 64'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        o;
    logic [31:0] a, b;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (2) @(negedge clk);
    lit("rst_busy", 64'(bus.busy), 64'h0);
    lit("rst_done", 64'(bus.done), 64'h0);
    lit("rst_hi", 64'(bus.hi), 64'h0);
    lit("rst_lo", 64'(bus.lo), 64'h0);
    lit("rst_aluop", 64'(bus.alu_operation), 64'h0);
    #2 reset = 1'b1;

    run_op(1'b0, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 1'b0, 0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFE, 32'd1, 1'b0, 0);
    run_op(1'b1, 32'd55, 32'd0, 1'b1, 32'd55, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(1'b0, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0, 5);

    // reset in the middle of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 32'd9; bus.operand_b = 32'd11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    lit("mid_rst_busy", 64'(bus.busy), 64'h0);
    lit("mid_rst_done", 64'(bus.done), 64'h0);
    lit("mid_rst_hi", 64'(bus.hi), 64'h0);
    lit("mid_rst_lo", 64'(bus.lo), 64'h0);
    lit("mid_rst_aluop", 64'(bus.alu_operation), 64'h0);
    lit("mid_rst_alu_a", 64'(bus.alu_a), 64'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    run_op(1'b0, 32'd123, 32'd456, 1'b1, 32'd0, 32'd56088, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
      run_op(o, a, b, 1'b0, '0, '0, 1'b0, int'($urandom_range(0, 40)));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
